// File: rtl/serial_adder.sv
// Bit-serial adder: operands are consumed LSB-first through a one-bit full adder
// built from two half adders, with valid/ready handshakes on both sides.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;

  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic fa_s, fa_c;

  half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]),  .s(ha0_s), .c(ha0_c));
  half_adder u_ha1 (.a(ha0_s),  .b(carry_q), .s(ha1_s), .c(ha1_c));

  assign fa_s = ha1_s;
  assign fa_c = ha0_c | ha1_c;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          res_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Sum bits enter at the top so the first (LSB) bit ends up in bit 0.
        res_d[WIDTH-1:0] = (res_q[WIDTH-1:0] >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          res_d[WIDTH] = fa_c;
          state_d      = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_sum   = res_q;
endmodule
